// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// PC/write-back mux selects and halt causes.
package cpu_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10
  } wb_sel_e;

  typedef enum logic [1:0] {
    HC_NONE    = 2'b00,
    HC_ECALL   = 2'b01,
    HC_ILLEGAL = 2'b10,
    HC_TIMEOUT = 2'b11
  } halt_cause_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; flags a timeout once the count
// reaches MEM_TIMEOUT (0 disables the timeout).
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int unsigned W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  logic [W-1:0] r_cnt;

  // Idle or completed requests clear the count, so every IF/MEM entry starts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (!i_active || i_ready)
      r_cnt <= '0;
    else if (!o_timeout)
      r_cnt <= r_cnt + W'(1);
  end

  assign o_timeout = (MEM_TIMEOUT != 0) && (r_cnt == W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: IF/ID/EX/MEM/WB sequencing, memory handshake,
// instruction retirement and halt handling.
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        if_sel,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic [31:0] instret,
  output logic        halted,
  output logic [1:0]  halt_cause,
  output logic [2:0]  state
);

  state_e      r_state, w_next;
  halt_cause_e r_halt_cause, w_halt_cause;
  logic [31:0] r_instret;
  logic        w_timeout;
  logic        w_active;
  logic        w_mem_done;

  assign w_active   = (r_state == S_IF) || (r_state == S_MEM);
  // Timeout wins over a late mem_ready; reset suppresses any completion pulse.
  assign w_mem_done = mem_ready && !w_timeout && !rst;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_active  (w_active),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IF;
      r_halt_cause <= HC_NONE;
    end else begin
      r_state      <= w_next;
      r_halt_cause <= w_halt_cause;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_instret <= '0;
    else if (retire)
      r_instret <= r_instret + 32'd1;
  end

  always_comb begin
    w_next       = r_state;
    w_halt_cause = r_halt_cause;
    case (r_state)
      S_IF: begin
        if (w_timeout) begin
          w_next       = S_HALT;
          w_halt_cause = HC_TIMEOUT;
        end else if (mem_ready) begin
          w_next = S_ID;
        end
      end
      S_ID: begin
        if (opcode == OP_SYSTEM) begin
          w_next       = S_HALT;
          w_halt_cause = HC_ECALL;
        end else if (!is_legal_op(opcode)) begin
          w_next       = S_HALT;
          w_halt_cause = HC_ILLEGAL;
        end else begin
          w_next = S_EX;
        end
      end
      S_EX: begin
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEM;
          OP_BRANCH:         w_next = S_IF;
          default:           w_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (w_timeout) begin
          w_next       = S_HALT;
          w_halt_cause = HC_TIMEOUT;
        end else if (mem_ready) begin
          w_next = (opcode == OP_LOAD) ? S_WB : S_IF;
        end
      end
      S_WB:    w_next = S_IF;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IF;
    endcase
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if_sel     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_PLUS4;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALU;
    retire     = 1'b0;
    halted     = (r_state == S_HALT);
    halt_cause = r_halt_cause;
    state      = r_state;
    instret    = r_instret;
    case (r_state)
      S_IF: begin
        mem_read = !w_timeout;
        if_sel   = 1'b1;
        ir_write = w_mem_done;
        pc_write = w_mem_done;
      end
      S_EX: begin
        alu_src_a = (opcode == OP_AUIPC);
        alu_src_b = (opcode == OP_I) || (opcode == OP_LOAD) || (opcode == OP_STORE)
                 || (opcode == OP_LUI) || (opcode == OP_AUIPC);
        case (opcode)
          OP_BRANCH: begin
            pc_write = branch_taken;
            pc_src   = PC_TARGET;
            retire   = !rst;
          end
          OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_TARGET;
          end
          OP_JALR: begin
            pc_write = 1'b1;
            pc_src   = PC_JALR;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        if (opcode == OP_LOAD)
          mem_read = !w_timeout;
        else
          mem_write = !w_timeout;
        retire = (opcode != OP_LOAD) && w_mem_done;
      end
      S_WB: begin
        reg_write = (rd != 5'd0) && !rst;
        retire    = !rst;
        if (opcode == OP_LOAD)
          wb_sel = WB_LOAD;
        else if ((opcode == OP_JAL) || (opcode == OP_JALR))
          wb_sel = WB_LINK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_read;
  logic        mem_write;
  logic        if_sel;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic        alu_src_b;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        retire;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [2:0]  state;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int start   = 0;

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, AUIPC = 7'b0010111, SYS = 7'b1110011;

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .rd           (rd),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .if_sel       (if_sel),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted),
    .halt_cause   (halt_cause),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0; rd = '0; branch_taken = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_if_sel", if_sel, 1);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_reg_write", reg_write, 0);
    chk("rst_retire", retire, 0);
    chk("rst_instret", instret, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", halt_cause, 0);
    #5;

    // add x5
    rst = 1'b0; opcode = R; rd = 5'd5; mem_ready = 1'b1; #1;
    start = cyc;
    chk("add_if_state", state, 0);
    chk("add_if_ir_write", ir_write, 1);
    chk("add_if_pc_write", pc_write, 1);
    chk("add_if_pc_src", pc_src, 0);
    chk("add_if_retire", retire, 0);
    chk("add_if_reg_write", reg_write, 0);
    tick;
    chk("add_id_state", state, 1);
    chk("add_id_mem_read", mem_read, 0);
    tick;
    chk("add_ex_state", state, 2);
    chk("add_ex_alu_src_b", alu_src_b, 0);
    chk("add_ex_pc_write", pc_write, 0);
    tick;
    chk("add_wb_state", state, 4);
    chk("add_wb_reg_write", reg_write, 1);
    chk("add_wb_wb_sel", wb_sel, 0);
    chk("add_wb_retire", retire, 1);
    chk("add_wb_instret", instret, 0);
    tick;
    chk("add_done_state", state, 0);
    chk("add_cycles", cyc - start, 4);
    chk("add_instret", instret, 1);
    chk("add_retire_clr", retire, 0);

    // load with three wait cycles in MEM
    opcode = LD; rd = 5'd3; #1;
    start = cyc;
    chk("ld_if_ir_write", ir_write, 1);
    tick; tick;
    chk("ld_ex_alu_src_b", alu_src_b, 1);
    mem_ready = 1'b0;
    tick;
    chk("ld_mem1_state", state, 3);
    chk("ld_mem1_read", mem_read, 1);
    chk("ld_mem1_if_sel", if_sel, 0);
    tick;
    chk("ld_mem2_read", mem_read, 1);
    tick;
    chk("ld_mem3_read", mem_read, 1);
    chk("ld_mem3_write", mem_write, 0);
    tick;
    mem_ready = 1'b1; #1;
    chk("ld_mem4_state", state, 3);
    chk("ld_mem4_read", mem_read, 1);
    chk("ld_mem4_retire", retire, 0);
    tick;
    chk("ld_wb_state", state, 4);
    chk("ld_wb_sel", wb_sel, 1);
    chk("ld_wb_reg_write", reg_write, 1);
    chk("ld_wb_retire", retire, 1);
    tick;
    chk("ld_cycles", cyc - start, 8);
    chk("ld_instret", instret, 2);

    // beq taken, then not taken
    opcode = BR; branch_taken = 1'b1; #1;
    start = cyc;
    tick; tick;
    chk("bt_ex_pc_write", pc_write, 1);
    chk("bt_ex_pc_src", pc_src, 1);
    chk("bt_ex_retire", retire, 1);
    chk("bt_ex_reg_write", reg_write, 0);
    tick;
    chk("bt_state", state, 0);
    chk("bt_cycles", cyc - start, 3);
    chk("bt_instret", instret, 3);
    branch_taken = 1'b0;
    start = cyc;
    tick; tick;
    chk("bn_ex_pc_write", pc_write, 0);
    chk("bn_ex_pc_src", pc_src, 1);
    chk("bn_ex_retire", retire, 1);
    tick;
    chk("bn_cycles", cyc - start, 3);
    chk("bn_instret", instret, 4);

    // addi x0
    opcode = I; rd = 5'd0; #1;
    start = cyc;
    tick; tick;
    chk("addi0_ex_alu_src_b", alu_src_b, 1);
    tick;
    chk("addi0_wb_reg_write", reg_write, 0);
    chk("addi0_wb_retire", retire, 1);
    tick;
    chk("addi0_cycles", cyc - start, 4);
    chk("addi0_instret", instret, 5);

    // store, zero-wait
    opcode = ST; rd = 5'd7; #1;
    start = cyc;
    tick; tick; tick;
    chk("st_mem_state", state, 3);
    chk("st_mem_write", mem_write, 1);
    chk("st_mem_read", mem_read, 0);
    chk("st_mem_if_sel", if_sel, 0);
    chk("st_mem_retire", retire, 1);
    chk("st_mem_reg_write", reg_write, 0);
    tick;
    chk("st_cycles", cyc - start, 4);
    chk("st_instret", instret, 6);

    // jal, jalr, auipc
    opcode = JAL; rd = 5'd1; #1;
    tick; tick;
    chk("jal_ex_pc_write", pc_write, 1);
    chk("jal_ex_pc_src", pc_src, 1);
    tick;
    chk("jal_wb_sel", wb_sel, 2);
    chk("jal_wb_reg_write", reg_write, 1);
    tick;
    opcode = JALR; #1;
    tick; tick;
    chk("jalr_ex_pc_src", pc_src, 2);
    chk("jalr_ex_pc_write", pc_write, 1);
    tick;
    chk("jalr_wb_sel", wb_sel, 2);
    tick;
    opcode = AUIPC; #1;
    tick; tick;
    chk("auipc_ex_alu_src_a", alu_src_a, 1);
    chk("auipc_ex_alu_src_b", alu_src_b, 1);
    tick; tick;
    chk("auipc_instret", instret, 9);

    // illegal opcode
    opcode = 7'b0000000; #1;
    tick;
    chk("ill_id_state", state, 1);
    tick;
    chk("ill_state", state, 5);
    chk("ill_halted", halted, 1);
    chk("ill_cause", halt_cause, 2);
    chk("ill_mem_read", mem_read, 0);
    chk("ill_instret", instret, 9);

    // reset clears halt; then ecall
    rst = 1'b1; #1;
    chk("rst2_state", state, 0);
    chk("rst2_instret", instret, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_cause", halt_cause, 0);
    rst = 1'b0; opcode = SYS; mem_ready = 1'b1; #1;
    tick; tick;
    chk("ecall_state", state, 5);
    chk("ecall_cause", halt_cause, 1);
    chk("ecall_halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      mem_ready = ~mem_ready;
      tick;
      chk("halt_hold_halted", halted, 1);
      chk("halt_hold_mem_read", mem_read, 0);
      chk("halt_hold_ir_write", ir_write, 0);
      chk("halt_hold_state", state, 5);
    end

    // fetch timeout: 4 waiting cycles, request drops on the 5th, then HALT
    rst = 1'b1; mem_ready = 1'b0; #1;
    rst = 1'b0; opcode = R; #1;
    chk("to_c1_mem_read", mem_read, 1);
    tick; tick; tick;
    chk("to_c4_mem_read", mem_read, 1);
    chk("to_c4_state", state, 0);
    tick;
    chk("to_c5_mem_read", mem_read, 0);
    chk("to_c5_ir_write", ir_write, 0);
    chk("to_c5_state", state, 0);
    tick;
    chk("to_state", state, 5);
    chk("to_cause", halt_cause, 3);
    chk("to_halted", halted, 1);

    // reset in the middle of a load's write-back
    rst = 1'b1; #1;
    rst = 1'b0; mem_ready = 1'b1; opcode = I; rd = 5'd2; #1;
    tick; tick; tick; tick;
    chk("pre_instret", instret, 1);
    opcode = LD; #1;
    tick; tick; tick; tick;
    chk("mid_wb_state", state, 4);
    chk("mid_wb_retire", retire, 1);
    rst = 1'b1; #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_retire", retire, 0);
    chk("mid_rst_reg_write", reg_write, 0);
    chk("mid_rst_ir_write", ir_write, 0);
    chk("mid_rst_pc_write", pc_write, 0);
    chk("mid_rst_mem_read", mem_read, 1);
    chk("mid_rst_if_sel", if_sel, 1);
    chk("mid_rst_mem_write", mem_write, 0);
    chk("mid_rst_wb_sel", wb_sel, 0);
    chk("mid_rst_instret", instret, 0);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_cause", halt_cause, 0);
    tick;
    chk("mid_rst_instret_hold", instret, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
